// File: rtl/dxp_cache_pkg.sv
// Shared constants and FSM encoding for the CAM lookup/allocate controller.
package dxp_cache_pkg;

    // Default geometry: tags are arg_max-4 bits wide, 2**AddrW lines.
    localparam int unsigned ArgMaxDefault = 7;
    localparam int unsigned TagW          = ArgMaxDefault - 4;
    localparam int unsigned AddrW         = 4;
    localparam int unsigned LinesDefault  = 1 << AddrW;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StReadv,
        StWrite,
        StResp
    } cam_state_e;

endpackage

// File: rtl/dxp_cam_ctrl_if.sv
// Request/response handshake and CAM-side bus of the CAM controller.
interface dxp_cam_ctrl_if
    import dxp_cache_pkg::*;
#(
    parameter int unsigned tag_w     = TagW,
    parameter int unsigned addrs_max = AddrW,
    parameter int unsigned bl_max    = LinesDefault
);
    logic                 req_vld;
    logic                 req_rdy;
    logic [tag_w-1:0]     req_tag;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic                 rsp_hit;
    logic [addrs_max-1:0] rsp_addrs;
    logic                 rsp_evict;
    logic [tag_w-1:0]     rsp_vtag;
    logic                 cam_we;
    logic                 cam_rd;
    logic [tag_w-1:0]     cam_din;
    logic [tag_w-1:0]     cam_argin;
    logic [addrs_max-1:0] cam_addrs;
    logic [tag_w-1:0]     cam_dout;
    logic [bl_max-1:0]    cam_mbits;

    // Controller side.
    modport slave (
        input  req_vld, req_tag, rsp_rdy, cam_dout, cam_mbits,
        output req_rdy, rsp_vld, rsp_hit, rsp_addrs, rsp_evict, rsp_vtag,
        output cam_we, cam_rd, cam_din, cam_argin, cam_addrs
    );

    // Requester plus CAM array side.
    modport master (
        output req_vld, req_tag, rsp_rdy, cam_dout, cam_mbits,
        input  req_rdy, rsp_vld, rsp_hit, rsp_addrs, rsp_evict, rsp_vtag,
        input  cam_we, cam_rd, cam_din, cam_argin, cam_addrs
    );

endinterface

// File: rtl/dxp_prio_enc.sv
// Lowest-index priority encoder with a found flag.
module dxp_prio_enc
    import dxp_cache_pkg::*;
#(
    parameter int unsigned width = LinesDefault,
    parameter int unsigned idx_w = AddrW
) (
    input  logic [width-1:0] req,
    output logic [idx_w-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = width - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = idx_w'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dxp_cam_ctrl.sv
// CAM lookup/allocate controller: hit search, victim selection, read-old/write-new, response.
module dxp_cam_ctrl
    import dxp_cache_pkg::*;
#(
    parameter int unsigned arg_max   = ArgMaxDefault,
    parameter int unsigned addrs_max = AddrW,
    parameter int unsigned bl_max    = LinesDefault
) (
    input logic            clk,
    input logic            rst_n,
    dxp_cam_ctrl_if.slave  bus
);

    localparam int unsigned tag_w = arg_max - 4;

    cam_state_e           state_q, state_d;
    logic [tag_w-1:0]     tag_q, tag_d;
    logic [addrs_max-1:0] addrs_q, addrs_d;
    logic [addrs_max-1:0] ptr_q, ptr_d;
    logic                 hit_q, hit_d;
    logic                 evict_q, evict_d;
    logic [tag_w-1:0]     vtag_q, vtag_d;
    logic [bl_max-1:0]    valid_q, valid_d;

    logic [bl_max-1:0]    hit_vec;
    logic [addrs_max-1:0] hit_idx, inv_idx;
    logic                 hit_found, inv_found;

    // Only resident lines may match.
    assign hit_vec = bus.cam_mbits & valid_q;

    dxp_prio_enc #(
        .width (bl_max),
        .idx_w (addrs_max)
    ) u_hit_enc (
        .req   (hit_vec),
        .idx   (hit_idx),
        .found (hit_found)
    );

    dxp_prio_enc #(
        .width (bl_max),
        .idx_w (addrs_max)
    ) u_inv_enc (
        .req   (~valid_q),
        .idx   (inv_idx),
        .found (inv_found)
    );

    // Gated by rst_n so the request side stays quiet while reset is held.
    assign bus.req_rdy   = (state_q == StIdle) & rst_n;
    assign bus.rsp_vld   = (state_q == StResp);
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_addrs = addrs_q;
    assign bus.rsp_evict = evict_q;
    assign bus.rsp_vtag  = vtag_q;
    assign bus.cam_argin = tag_q;

    // State and datapath registers; reset clears residency and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tag_q   <= '0;
            addrs_q <= '0;
            ptr_q   <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
            vtag_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            addrs_q <= addrs_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            evict_q <= evict_d;
            vtag_q  <= vtag_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic and CAM strobes.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        addrs_d       = addrs_q;
        ptr_d         = ptr_q;
        hit_d         = hit_q;
        evict_d       = evict_q;
        vtag_d        = vtag_q;
        valid_d       = valid_q;
        bus.cam_we    = 1'b0;
        bus.cam_rd    = 1'b0;
        bus.cam_din   = '0;
        bus.cam_addrs = '0;

        case (state_q)
            StIdle: begin
                if (bus.req_vld) begin
                    tag_d   = bus.req_tag;
                    hit_d   = 1'b0;
                    evict_d = 1'b0;
                    vtag_d  = '0;
                    addrs_d = '0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit_found) begin
                    hit_d   = 1'b1;
                    addrs_d = hit_idx;
                    state_d = StResp;
                end else begin
                    // Prefer a free line; fall back to round-robin replacement.
                    addrs_d = inv_found ? inv_idx : ptr_q;
                    state_d = StReadv;
                end
            end
            StReadv: begin
                bus.cam_rd    = 1'b1;
                bus.cam_addrs = addrs_q;
                vtag_d        = bus.cam_dout;
                evict_d       = valid_q[addrs_q];
                // Pointer moves only when a resident tag is displaced.
                if (valid_q[addrs_q]) begin
                    ptr_d = ptr_q + {{(addrs_max-1){1'b0}}, 1'b1};
                end
                state_d = StWrite;
            end
            StWrite: begin
                bus.cam_we       = 1'b1;
                bus.cam_addrs    = addrs_q;
                bus.cam_din      = tag_q;
                valid_d[addrs_q] = 1'b1;
                state_d          = StResp;
            end
            StResp: begin
                if (bus.rsp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_dxp_cam_ctrl.sv
// Directed self-checking bench for dxp_cam_ctrl with a behavioural CAM array.
module tb_dxp_cam_ctrl;

    // 5-bit tags so that 16 lines can hold distinct tags and still leave new ones to evict with.
    localparam int unsigned ArgMax = 9;
    localparam int unsigned TagW   = ArgMax - 4;
    localparam int unsigned AddrW  = 4;
    localparam int unsigned Lines  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cam_init;

    int n_chk    = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int both_cnt = 0;
    logic [AddrW-1:0] we_addr;
    logic [TagW-1:0]  we_din;
    logic [TagW-1:0]  mem [Lines];

    always #5 clk = ~clk;

    dxp_cam_ctrl_if #(
        .tag_w     (TagW),
        .addrs_max (AddrW),
        .bl_max    (Lines)
    ) bus ();

    dxp_cam_ctrl #(
        .arg_max   (ArgMax),
        .addrs_max (AddrW),
        .bl_max    (Lines)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // CAM array: all-ones init on request, synchronous write, async read and match.
    always @(posedge clk) begin
        if (bus.cam_we && bus.cam_rd) both_cnt <= both_cnt + 1;
        if (cam_init) begin
            for (int i = 0; i < Lines; i++) mem[i] <= '1;
        end else if (bus.cam_we) begin
            mem[bus.cam_addrs] <= bus.cam_din;
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.cam_addrs;
            we_din  <= bus.cam_din;
        end
    end

    assign bus.cam_dout = mem[bus.cam_addrs];

    always_comb begin
        bus.cam_mbits = '0;
        for (int i = 0; i < Lines; i++) bus.cam_mbits[i] = (mem[i] == bus.cam_argin);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction; exp_vtag is whatever the CAM held in the victim line.
    task automatic run_req(input string nm, input logic [TagW-1:0] tag, input logic exp_hit,
                           input logic [AddrW-1:0] exp_addrs, input logic exp_evict,
                           input logic [TagW-1:0] exp_vtag, input int hold);
        int lat;
        int we0;
        @(negedge clk);
        check_eq({nm, ".req_rdy"}, 32'(bus.req_rdy), 1);
        we0         = we_cnt;
        bus.req_vld = 1'b1;
        bus.req_tag = tag;
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
        lat = 1;
        while (!bus.rsp_vld && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({nm, ".lat"}, 32'(lat), exp_hit ? 2 : 4);
        check_eq({nm, ".hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
        check_eq({nm, ".addrs"}, 32'(bus.rsp_addrs), 32'(exp_addrs));
        check_eq({nm, ".evict"}, 32'(bus.rsp_evict), 32'(exp_evict));
        check_eq({nm, ".vtag"}, 32'(bus.rsp_vtag), 32'(exp_vtag));
        check_eq({nm, ".we_cnt"}, 32'(we_cnt - we0), exp_hit ? 0 : 1);
        if (!exp_hit) begin
            check_eq({nm, ".we_addr"}, 32'(we_addr), 32'(exp_addrs));
            check_eq({nm, ".we_din"}, 32'(we_din), 32'(tag));
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check_eq({nm, ".hold"},
                     32'({bus.rsp_vld, bus.req_rdy, bus.rsp_hit, bus.rsp_evict,
                          bus.rsp_addrs, bus.rsp_vtag}),
                     32'({1'b1, 1'b0, exp_hit, exp_evict, exp_addrs, exp_vtag}));
        end
        bus.rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_rdy = 1'b0;
        check_eq({nm, ".done"}, 32'(bus.rsp_vld), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_vld = 1'b0;
        bus.req_tag = '0;
        bus.rsp_rdy = 1'b0;
        cam_init    = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.outs",
                 32'({bus.req_rdy, bus.rsp_vld, bus.rsp_hit, bus.rsp_evict, bus.rsp_addrs,
                      bus.rsp_vtag, bus.cam_we, bus.cam_rd, bus.cam_din, bus.cam_argin,
                      bus.cam_addrs}), 0);
        cam_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst.req_rdy", 32'(bus.req_rdy), 1);

        // First miss after reset lands in line 0; response held off for 5 cycles.
        run_req("a_miss", 5'b00101, 1'b0, 4'd0, 1'b0, 5'h1f, 5);
        run_req("b_hit", 5'b00101, 1'b1, 4'd0, 1'b0, 5'h00, 0);

        // Fresh reset with all-ones CAM contents: matching stale lines must not hit.
        @(negedge clk);
        rst_n    = 1'b0;
        cam_init = 1'b1;
        @(posedge clk);
        #1;
        cam_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req("c_ones", 5'h1f, 1'b0, 4'd0, 1'b0, 5'h1f, 0);

        // Fill lines 1..15 with tags 16..30.
        for (int t = 0; t < 15; t++) begin
            run_req("fill", TagW'(16 + t), 1'b0, AddrW'(t + 1), 1'b0, 5'h1f, 0);
        end

        // Full CAM: evictions walk the pointer 0..15 and wrap to 0.
        run_req("evict0", 5'd0, 1'b0, 4'd0, 1'b1, 5'h1f, 0);
        for (int k = 1; k < 16; k++) begin
            run_req("evict_rr", TagW'(k), 1'b0, AddrW'(k), 1'b1, TagW'(15 + k), 0);
        end
        run_req("evict_wrap", 5'd16, 1'b0, 4'd0, 1'b1, 5'd0, 0);

        // Reset in the middle of the write to line 1 (pointer is 1).
        @(negedge clk);
        bus.req_vld = 1'b1;
        bus.req_tag = 5'd20;
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
        @(posedge clk);
        #1;
        check_eq("e.cam_rd", 32'({bus.cam_rd, bus.cam_we}), 32'h2);
        @(posedge clk);
        #1;
        check_eq("e.cam_we", 32'({bus.cam_we, bus.cam_rd, bus.cam_addrs}), 32'h21);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("e.we_async", 32'({bus.cam_we, bus.rsp_vld, bus.req_rdy}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("e.nowrite", 32'(mem[1]), 1);
        // Previously resident tags now miss into free lines without eviction.
        run_req("e_post0", 5'd16, 1'b0, 4'd0, 1'b0, 5'd16, 0);
        run_req("e_post1", 5'd1, 1'b0, 4'd1, 1'b0, 5'd1, 0);

        check_eq("we_rd_overlap", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
